seg7_scan_decoder: RTL and testbench

Receives a multiplexed, active-low common-anode 7-segment display bus (segment lines plus per-digit anode strobes) and recovers the BCD value of every digit. It sits on the observation and readback side of the display path, so a self-test or logger can read back what the display driver is showing. Each digit is sampled only after its pattern has been stable for a programmable dwell. Results are published one whole frame at a time, so the digits in a frame always belong together.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_to_bcd.sv | 27 ++
 rtl/seg7_scan_decoder.sv | 99 +++++++++
 tb/tb_seg7_scan_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, BCD codes and FSM states for the 7-segment scan decoder
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_BLANK = 4'hA;
  localparam logic [3:0] BCD_ERR   = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_HELD} state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational active-low segment pattern to {err, bcd} decoder
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic [3:0] bcd
);
  always_comb begin
    err = 1'b0;
    bcd = BCD_ERR;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   err = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit BCD from a multiplexed 7-seg bus, published per frame; SEG7_SYNC_EN adds input synchronizers
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err
);
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;
`ifdef SEG7_SYNC_EN
  logic [6:0]              r_seg_s1, r_seg_s2;
  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_in;
      r_an_s2  <= r_an_s1;
    end
  end
  assign w_seg = r_seg_s2;
  assign w_an  = r_an_s2;
`else
  assign w_seg = seg_in;
  assign w_an  = an_in;
`endif
  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an, r_seen, r_sh_err;
  logic [4*NUM_DIGITS-1:0] r_sh_bcd;
  logic [NUM_DIGITS-1:0]   w_act;
  logic                    w_valid, w_same, w_cap, w_err;
  logic [3:0]              w_bcd;
  seg7_to_bcd u_dec (.seg(w_seg), .err(w_err), .bcd(w_bcd));
  assign w_act   = ~w_an;
  assign w_valid = $onehot(w_act);
  assign w_same  = (w_an == r_an) && (w_seg == r_seg);
  assign w_cap   = w_valid && w_same && (r_state == S_DWELL) && (r_cnt + 8'd1 == STB);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_an        <= '1;
      r_seg       <= '1;
      r_seen      <= '0;
      r_sh_bcd    <= '0;
      r_sh_err    <= '0;
      bcd_out     <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_an        <= w_an;
      r_seg       <= w_seg;
      frame_valid <= 1'b0;
      if (!w_valid) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (r_state == S_IDLE || !w_same) begin
        r_state <= S_DWELL;
        r_cnt   <= 8'd1;
      end else if (r_state == S_DWELL) begin
        r_cnt   <= r_cnt + 8'd1;
        r_state <= w_cap ? S_HELD : S_DWELL;
      end
      for (int i = 0; i < NUM_DIGITS; i++)
        if (w_cap && w_act[i]) begin
          r_sh_bcd[4*i +: 4] <= w_bcd;
          r_sh_err[i]        <= w_err;
        end
      // publish the completed frame; a coinciding capture seeds the next one
      if (&r_seen) begin
        bcd_out     <= r_sh_bcd;
        digit_err   <= r_sh_err;
        frame_err   <= |r_sh_err;
        frame_valid <= 1'b1;
        r_seen      <= w_cap ? w_act : '0;
      end else if (w_cap) begin
        r_seen <= r_seen | w_act;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table-driven, directed and random checks against a run-length reference model
module tb_seg7_scan_decoder;
  localparam int N = 4, S = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic [N-1:0] an_in = '1;
  logic [4*N-1:0] bcd_out;
  logic [N-1:0] digit_err;
  logic frame_valid, frame_err;
  always #5 clk = ~clk;
  seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .digit_err(digit_err), .frame_valid(frame_valid), .frame_err(frame_err)
  );
  int checks = 0, failures = 0, pulses = 0;
  logic [15:0] last_bcd;
  logic [3:0] last_err;
  logic last_ferr;
  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  typedef struct {
    logic [3:0][6:0] segs;
    logic [15:0] bcd;
    logic [3:0] err;
    logic ferr;
  } vec_t;
  vec_t vecs [3];
  logic [15:0] m_bcd, m_sh_bcd;
  logic [3:0] m_err, m_sh_err, m_seen, m_pa, m_sa1, m_sa2;
  logic [6:0] m_ps, m_ss1, m_ss2;
  logic m_ferr, m_fv, m_pv;
  int m_run;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (s == pats[k]) return {1'b0, 4'(k)};
    if (s == 7'h7F) return {1'b0, 4'hA};
    return {1'b1, 4'hF};
  endfunction
  task automatic model(input logic [N-1:0] a_in, input logic [6:0] s_in, input logic r);
    logic [N-1:0] a, nseen;
    logic [6:0] s;
    logic [4:0] dec;
    int zeros, d;
    logic v;
    m_fv = 1'b0;
    if (r) begin
      m_bcd = '0; m_err = '0; m_ferr = 1'b0; m_sh_bcd = '0; m_sh_err = '0; m_seen = '0;
      m_pv = 1'b0; m_run = 0; m_sa1 = '1; m_sa2 = '1; m_ss1 = '1; m_ss2 = '1;
      return;
    end
`ifdef SEG7_SYNC_EN
    a = m_sa2; s = m_ss2;
    m_sa2 = m_sa1; m_ss2 = m_ss1; m_sa1 = a_in; m_ss1 = s_in;
`else
    a = a_in; s = s_in;
`endif
    zeros = 0; d = 0;
    for (int i = 0; i < N; i++) if (!a[i]) begin zeros++; d = i; end
    v = (zeros == 1);
    nseen = m_seen;
    if (m_seen == 4'hF) begin
      m_bcd = m_sh_bcd; m_err = m_sh_err; m_ferr = |m_sh_err; m_fv = 1'b1; nseen = '0;
    end
    if (!v) m_run = 0;
    else if (m_pv && a == m_pa && s == m_ps) m_run++;
    else m_run = 1;
    if (v && m_run == S) begin
      dec = ref_dec(s);
      m_sh_bcd[4*d +: 4] = dec[3:0];
      m_sh_err[d] = dec[4];
      nseen[d] = 1'b1;
    end
    m_seen = nseen; m_pa = a; m_ps = s; m_pv = v;
  endtask
  task automatic step(input logic [N-1:0] a, input logic [6:0] s, input logic r);
    an_in = a; seg_in = s; rst = r;
    @(posedge clk);
    model(a, s, r);
    #1;
    chk("cycle", {10'd0, bcd_out, digit_err, frame_valid, frame_err}, {10'd0, m_bcd, m_err, m_fv, m_ferr});
    if (frame_valid) begin
      pulses++; last_bcd = bcd_out; last_err = digit_err; last_ferr = frame_err;
    end
  endtask
  task automatic strobe(input int i, input logic [6:0] s, input int n);
    logic [N-1:0] a;
    a = ~(4'b0001 << i);
    repeat (n) step(a, s, 1'b0);
  endtask
  task automatic scan(input logic [3:0][6:0] p);
    for (int i = 0; i < N; i++) strobe(i, p[i], 8);
    step('1, 7'h7F, 1'b0);
  endtask
  initial begin
    vecs[0] = '{segs: {pats[4], pats[3], pats[2], pats[1]}, bcd: 16'h4321, err: 4'b0000, ferr: 1'b0};
    vecs[1] = '{segs: {7'h7F, pats[0], 7'b1010101, pats[0]}, bcd: 16'hA0F0, err: 4'b0010, ferr: 1'b1};
    vecs[2] = '{segs: {pats[6], pats[7], pats[8], pats[9]}, bcd: 16'h6789, err: 4'b0000, ferr: 1'b0};
    repeat (3) step('1, 7'h7F, 1'b1);
    repeat (10) step('1, 7'h7F, 1'b0);
    chk("reset_bcd", 32'(bcd_out), 0);
    chk("reset_err", {27'd0, digit_err, frame_err}, 0);
    chk("reset_pulses", pulses, 0);
    for (int k = 0; k < 3; k++) begin
      pulses = 0;
      scan(vecs[k].segs);
      chk("vec_pulses", pulses, 1);
      chk("vec_bcd", 32'(last_bcd), 32'(vecs[k].bcd));
      chk("vec_err", 32'(last_err), 32'(vecs[k].err));
      chk("vec_ferr", 32'(last_ferr), 32'(vecs[k].ferr));
    end
    pulses = 0;
    strobe(0, pats[1], 8); strobe(1, pats[1], 8); strobe(3, pats[1], 8);
    repeat (4) begin
      strobe(2, pats[5], 3);
      strobe(2, pats[6], 3);
    end
    chk("glitch_pulses", pulses, 0);
    strobe(2, pats[5], 8);
    chk("glitch_recover_pulses", pulses, 1);
    chk("glitch_recover_bcd", 32'(last_bcd), 32'h1511);
    pulses = 0;
    strobe(0, pats[2], 8); strobe(1, pats[2], 8);
    repeat (10) step(4'b1100, pats[3], 1'b0);
    chk("multi_strobe_pulses", pulses, 0);
    strobe(2, pats[2], 8); strobe(3, pats[2], 8);
    step('1, 7'h7F, 1'b0);
    chk("multi_strobe_frame", pulses, 1);
    chk("multi_strobe_bcd", 32'(last_bcd), 32'h2222);
    pulses = 0;
    strobe(0, pats[5], 8); strobe(1, pats[5], 8);
    repeat (2) step('1, 7'h7F, 1'b1);
    chk("mid_reset_bcd", 32'(bcd_out), 0);
    scan(vecs[2].segs);
    chk("mid_reset_pulses", pulses, 1);
    chk("mid_reset_bcd_after", 32'(last_bcd), 32'h6789);
    repeat (400) begin
      int dur, sel;
      logic [N-1:0] a;
      logic [6:0] s;
      logic r;
      dur = $urandom_range(1, 8);
      sel = $urandom_range(0, 9);
      a = (sel < 7) ? ~(4'b0001 << (sel % 4)) : (sel == 7) ? 4'hF : 4'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 7'($urandom) : pats[$urandom_range(0, 9)];
      r = ($urandom_range(0, 99) == 0);
      repeat (dur) step(a, s, r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
